// File: rtl/serial_shift_unit.sv
// Bit-serial shifter: SLL/SRL/SRA (and ROR when SERIAL_SHIFT_ROTATE_EN is defined), one bit per clock.
// With SERIAL_SHIFT_ROTATE_EN undefined, op 11 is folded into SRL at capture and no rotate logic exists.
module serial_shift_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [31:0]      shamt,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             busy
);
  // state | meaning
  // IDLE  | waiting for start
  // SHIFT | one bit shifted per edge, counter > 0
  // DONE  | out valid for one cycle; a start here chains the next request
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0]       OP_SLL    = 2'b00;
  localparam logic [1:0]       OP_SRL    = 2'b01;
  localparam logic [1:0]       OP_SRA    = 2'b10;
  localparam logic [1:0]       OP_ROR    = 2'b11;
  localparam logic [31:0]      WIDTH32   = 32'(WIDTH);
  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_work, w_work_shifted;
  logic [WIDTH-1:0] r_out;
  logic [CNT_W-1:0] r_cnt, w_n;
  logic [1:0]       r_op, w_op_eff;
  logic             w_capture;

`ifdef SERIAL_SHIFT_ROTATE_EN
  logic [31:0] w_rot_amt;
  assign w_rot_amt = shamt % WIDTH32;
  assign w_op_eff  = op;
`else
  assign w_op_eff  = (op == OP_ROR) ? OP_SRL : op;
`endif

  always_comb begin
    w_n = (shamt >= WIDTH32) ? WIDTH_CNT : shamt[CNT_W-1:0];
`ifdef SERIAL_SHIFT_ROTATE_EN
    if (op == OP_ROR) w_n = w_rot_amt[CNT_W-1:0];
`endif
  end

  always_comb begin
    w_work_shifted = r_work;
    case (r_op)
      OP_SLL:  w_work_shifted = {r_work[WIDTH-2:0], 1'b0};
      OP_SRL:  w_work_shifted = {1'b0, r_work[WIDTH-1:1]};
      OP_SRA:  w_work_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
`ifdef SERIAL_SHIFT_ROTATE_EN
      OP_ROR:  w_work_shifted = {r_work[0], r_work[WIDTH-1:1]};
`endif
      default: w_work_shifted = r_work;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_state_nxt = (w_n == '0) ? DONE : SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT:   if (r_cnt == CNT_ONE) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
      r_op    <= OP_SLL;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_work <= a;
        r_op   <= w_op_eff;
        r_cnt  <= w_n;
        if (w_n == '0) r_out <= a;
      end else if (r_state == SHIFT) begin
        r_work <= w_work_shifted;
        r_cnt  <= r_cnt - CNT_ONE;
        // last shift lands straight in out so it is valid on DONE entry
        if (r_cnt == CNT_ONE) r_out <= w_work_shifted;
      end
    end
  end

  assign out  = r_out;
  assign done = (r_state == DONE);
  assign busy = (r_state == SHIFT);

endmodule
